// File: rtl/vx_flush_tag_arb_pkg.sv
// Shared cache configuration for the flush/fill tag-write arbiter.
// Provides the LINE_SELECT_BITS derivation and the tag-write command struct template.
`ifndef VX_FLUSH_TAG_ARB_PKG_SV
`define VX_FLUSH_TAG_ARB_PKG_SV

`define LINE_SELECT_BITS(cs, ls, nb) $clog2((cs) / ((ls) * (nb)))

// Tag-write command; widths depend on the instance, so the struct body is a template.
`define VX_TAG_CMD_T(lw, tw) struct packed { logic we; logic [(lw)-1:0] line; logic [(tw)-1:0] data; logic valid; }

package vx_flush_tag_arb_pkg;

    // A single-line cache still needs a 1-bit physical index bus.
    function automatic int line_w(input int lsb);
        return (lsb > 0) ? lsb : 1;
    endfunction

endpackage

`endif

// File: rtl/vx_flush_tag_arb_if.sv
// Flush sweep, fill request and tag-store write bundle of the flush/fill tag arbiter.
interface vx_flush_tag_arb_if #(
    parameter int LINE_W    = 14,
    parameter int TAG_WIDTH = 16
);
    logic                 flush_valid_in;
    logic [LINE_W-1:0]    flush_addr_in;
    logic                 fill_valid;
    logic [LINE_W-1:0]    fill_line;
    logic [TAG_WIDTH-1:0] fill_tag;
    logic                 fill_ready;
    logic                 tag_we;
    logic [LINE_W-1:0]    tag_line;
    logic [TAG_WIDTH-1:0] tag_data;
    logic                 tag_valid;

    modport master (
        output flush_valid_in, flush_addr_in, fill_valid, fill_line, fill_tag,
        input  fill_ready, tag_we, tag_line, tag_data, tag_valid
    );

    modport slave (
        input  flush_valid_in, flush_addr_in, fill_valid, fill_line, fill_tag,
        output fill_ready, tag_we, tag_line, tag_data, tag_valid
    );
endinterface

// File: rtl/vx_flush_sweep_tracker.sv
// Follows the flush sweep: expected-line counter, busy flag, done pulse and sticky
// non-contiguity error.
module vx_flush_sweep_tracker #(
    parameter int LSB    = 14,
    parameter int LINE_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_valid_i,
    input  logic [LINE_W-1:0] flush_addr_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              sweep_err_o
);
    localparam logic [LINE_W-1:0] LAST = LINE_W'((1 << LSB) - 1);

    logic [LINE_W-1:0] exp_q, exp_d;
    logic              busy_q, busy_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    // last_q mirrors "output stage holds the LAST invalidate"; done needs a live sweep.
    assign flush_done_o = last_q & busy_q;
    assign flush_busy_o = busy_q;
    assign sweep_err_o  = err_q;

    always_comb begin
        exp_d  = exp_q;
        busy_d = busy_q;
        err_d  = err_q;
        last_d = flush_valid_i && (flush_addr_i == LAST);
        if (flush_valid_i && (flush_addr_i == '0)) begin
            busy_d = 1'b1;
        end else if (flush_done_o) begin
            busy_d = 1'b0;
        end
        if (flush_valid_i) begin
            if (flush_addr_i == '0) begin
                exp_d = LINE_W'(1) & LAST;
            end else if (flush_addr_i == exp_q) begin
                exp_d = (exp_q + 1'b1) & LAST;
            end else begin
                err_d = 1'b1;
                exp_d = (flush_addr_i + 1'b1) & LAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q  <= '0;
            busy_q <= 1'b0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            busy_q <= busy_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: rtl/vx_flush_tag_arb.sv
// Merges the non-stallable flush sweep with core fill tag writes into one registered
// tag-write command. Optional macro VX_FLUSH_TAG_ARB_PERF_EN adds a fill-stall counter.
module vx_flush_tag_arb
    import vx_flush_tag_arb_pkg::*;
#(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 1,
    parameter int NUM_BANKS       = 1,
    parameter int TAG_WIDTH       = 16
) (
    input  logic                clk,
    input  logic                reset,
    vx_flush_tag_arb_if.slave   bus,
    output logic                flush_busy,
    output logic                flush_done,
    output logic                sweep_err
`ifdef VX_FLUSH_TAG_ARB_PERF_EN
    ,
    output logic [31:0]         perf_fill_stalls
`endif
);
    localparam int LSB    = `LINE_SELECT_BITS(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
    localparam int LINE_W = line_w(LSB);

    typedef `VX_TAG_CMD_T(LINE_W, TAG_WIDTH) tag_cmd_t;

    tag_cmd_t cmd_q, cmd_d;
    logic     fill_accept;

    assign bus.fill_ready = ~bus.flush_valid_in & ~reset;
    assign fill_accept    = bus.fill_valid & bus.fill_ready;

    // Flush always wins; idle cycles drop the enable but keep the last command visible.
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        if (bus.flush_valid_in) begin
            cmd_d.we    = 1'b1;
            cmd_d.line  = bus.flush_addr_in;
            cmd_d.data  = '0;
            cmd_d.valid = 1'b0;
        end else if (fill_accept) begin
            cmd_d.we    = 1'b1;
            cmd_d.line  = bus.fill_line;
            cmd_d.data  = bus.fill_tag;
            cmd_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign bus.tag_we    = cmd_q.we;
    assign bus.tag_line  = cmd_q.line;
    assign bus.tag_data  = cmd_q.data;
    assign bus.tag_valid = cmd_q.valid;

    vx_flush_sweep_tracker #(
        .LSB    (LSB),
        .LINE_W (LINE_W)
    ) u_tracker (
        .clk           (clk),
        .reset         (reset),
        .flush_valid_i (bus.flush_valid_in),
        .flush_addr_i  (bus.flush_addr_in),
        .flush_busy_o  (flush_busy),
        .flush_done_o  (flush_done),
        .sweep_err_o   (sweep_err)
    );

`ifdef VX_FLUSH_TAG_ARB_PERF_EN
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        stalls_d = stalls_q;
        if (bus.fill_valid && !bus.fill_ready && (stalls_q != '1)) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stalls_q <= '0;
        end else begin
            stalls_q <= stalls_d;
        end
    end

    assign perf_fill_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_vx_flush_tag_arb.sv
// Directed self-checking bench for vx_flush_tag_arb with a 4-line cache (LSB=2).
module tb_vx_flush_tag_arb;
    localparam int LW = 2;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic reset;
    logic flush_busy;
    logic flush_done;
    logic sweep_err;
`ifdef VX_FLUSH_TAG_ARB_PERF_EN
    logic [31:0] perf_fill_stalls;
`endif

    int passCount  = 0;
    int checkCount = 0;

    vx_flush_tag_arb_if #(.LINE_W(LW), .TAG_WIDTH(TW)) bus ();

    vx_flush_tag_arb #(
        .CACHE_SIZE      (64),
        .CACHE_LINE_SIZE (16),
        .NUM_BANKS       (1),
        .TAG_WIDTH       (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .sweep_err  (sweep_err)
`ifdef VX_FLUSH_TAG_ARB_PERF_EN
        ,
        .perf_fill_stalls (perf_fill_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs === expv) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    endtask

    task automatic applyStimulus(input logic fv, input int fa, input logic filv, input int fl,
                                 input logic [TW-1:0] ft);
        bus.flush_valid_in = fv;
        bus.flush_addr_in  = LW'(fa);
        bus.fill_valid     = filv;
        bus.fill_line      = LW'(fl);
        bus.fill_tag       = ft;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCmd(input string tag, input logic we, input int line,
                            input logic [TW-1:0] data, input logic valid);
        checkOutput({tag, "_we"},    32'(bus.tag_we),    32'(we));
        checkOutput({tag, "_line"},  32'(bus.tag_line),  32'(line));
        checkOutput({tag, "_data"},  32'(bus.tag_data),  32'(data));
        checkOutput({tag, "_valid"}, 32'(bus.tag_valid), 32'(valid));
    endtask

    task automatic checkSweep(input string tag, input logic busy, input logic done, input logic err);
        checkOutput({tag, "_busy"}, 32'(flush_busy), 32'(busy));
        checkOutput({tag, "_done"}, 32'(flush_done), 32'(done));
        checkOutput({tag, "_err"},  32'(sweep_err),  32'(err));
    endtask

    task automatic runFlush(input string tag, input int a, input logic expDone);
        applyStimulus(1'b1, a, 1'b0, 0, '0);
        tick();
        checkCmd(tag, 1'b1, a, '0, 1'b0);
        checkOutput({tag, "_done"}, 32'(flush_done), 32'(expDone));
    endtask

    initial begin
        int restartSeq[6];
        restartSeq = '{0, 1, 0, 1, 2, 3};

        reset = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();
        tick();
        checkOutput("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
        reset = 1'b0;
        tick();
        checkCmd("idle", 1'b0, 0, '0, 1'b0);
        checkSweep("idle", 1'b0, 1'b0, 1'b0);
        checkOutput("idle_fill_ready", 32'(bus.fill_ready), 32'd1);

        // Full sweep while a fill waits on line 2.
        applyStimulus(1'b1, 0, 1'b1, 2, 16'hABCD);
        #1;
        checkOutput("sw_fill_ready", 32'(bus.fill_ready), 32'd0);
        tick();
        checkCmd("sw0", 1'b1, 0, '0, 1'b0);
        checkSweep("sw0", 1'b1, 1'b0, 1'b0);
        for (int a = 1; a < 4; a++) begin
            applyStimulus(1'b1, a, 1'b1, 2, 16'hABCD);
            tick();
            checkCmd("sw", 1'b1, a, '0, 1'b0);
            checkSweep("sw", 1'b1, (a == 3), 1'b0);
        end
        applyStimulus(1'b0, 0, 1'b1, 2, 16'hABCD);
        #1;
        checkOutput("fill_ready_after", 32'(bus.fill_ready), 32'd1);
        tick();
        checkCmd("fill", 1'b1, 2, 16'hABCD, 1'b1);
        checkSweep("fill", 1'b0, 1'b0, 1'b0);
`ifdef VX_FLUSH_TAG_ARB_PERF_EN
        checkOutput("perf_sw", perf_fill_stalls, 32'd4);
`endif
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();
        checkCmd("hold", 1'b0, 2, 16'hABCD, 1'b1);

        // Abandoned sweep then restart: a single done pulse.
        for (int i = 0; i < 6; i++) runFlush("restart", restartSeq[i], (i == 5));
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();
        checkSweep("restart_end", 1'b0, 1'b0, 1'b0);

        // Gap mid-sweep accepts a fill and keeps busy.
        runFlush("gap0", 0, 1'b0);
        runFlush("gap1", 1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1, 16'h1234);
        #1;
        checkOutput("gap_fill_ready", 32'(bus.fill_ready), 32'd1);
        tick();
        checkCmd("gapfill", 1'b1, 1, 16'h1234, 1'b1);
        checkOutput("gapfill_busy", 32'(flush_busy), 32'd1);
        runFlush("gap2", 2, 1'b0);
        runFlush("gap3", 3, 1'b1);
        checkOutput("gap_err", 32'(sweep_err), 32'd0);
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();

        // Skipped line sets the sticky error.
        runFlush("skip0", 0, 1'b0);
        runFlush("skip1", 1, 1'b0);
        runFlush("skip3", 3, 1'b1);
        checkOutput("skip_err", 32'(sweep_err), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();
        for (int a = 0; a < 4; a++) runFlush("post", a, (a == 3));
        checkOutput("sticky_err", 32'(sweep_err), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();

        // Reset mid-sweep with a blocked fill.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("err_cleared", 32'(sweep_err), 32'd0);
        applyStimulus(1'b1, 0, 1'b1, 3, 16'h5555);
        tick();
        applyStimulus(1'b1, 1, 1'b1, 3, 16'h5555);
        tick();
`ifdef VX_FLUSH_TAG_ARB_PERF_EN
        checkOutput("perf_pre_rst", perf_fill_stalls, 32'd2);
`endif
        applyStimulus(1'b1, 2, 1'b1, 3, 16'h5555);
        reset = 1'b1;
        tick();
        checkCmd("midrst", 1'b0, 0, '0, 1'b0);
        checkSweep("midrst", 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_fill_ready", 32'(bus.fill_ready), 32'd0);
`ifdef VX_FLUSH_TAG_ARB_PERF_EN
        checkOutput("perf_post_rst", perf_fill_stalls, 32'd0);
`endif
        reset = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, '0);
        tick();
        checkSweep("after_rst", 1'b0, 1'b0, 1'b0);
        checkOutput("after_rst_fill_ready", 32'(bus.fill_ready), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
